// File: rtl/shared_reg_wr_arbiter_pkg.sv
// Shared definitions for the shared-register write arbiter: FSM state encoding
// and an index-width helper.
package shared_reg_arb_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        WAIT_FULL  = 3'd2,
        WAIT_DRAIN = 3'd3,
        WAIT_REL   = 3'd4
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/shared_reg_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or above
// ptr, wrapping around to index 0.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             any,
    output logic [IW-1:0]    winner
);

    int unsigned off;
    int unsigned best_off;

    // Distance from ptr (modulo N_REQ) ranks each requester; smallest wins.
    always_comb begin
        any      = |req;
        winner   = '0;
        off      = 0;
        best_off = N_REQ;
        for (int j = 0; j < N_REQ; j++) begin
            off = (32'(j) + N_REQ - 32'(ptr)) % N_REQ;
            if (req[j] && (off < best_off)) begin
                best_off = off;
                winner   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/shared_reg_wr_arbiter.sv
// Round-robin arbiter sharing the write side of the 1-byte shared register;
// runs one full write / fill / drain / release cycle per grant.
module shared_reg_wr_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 8,
    localparam int unsigned IW   = clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    output logic                reg_wr,
    output logic [DW-1:0]       reg_wr_data,
    input  logic                reg_has_data,
    input  logic                reg_rd,
    output logic                busy,
    output logic [IW-1:0]       grant_idx
);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             reg_wr_q, reg_wr_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic [IW-1:0]    grant_q, grant_d;

    logic             pick_any;
    logic [IW-1:0]    pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ack_d     = '0;
        reg_wr_d  = 1'b0;
        wr_data_d = wr_data_q;
        grant_d   = grant_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    reg_wr_d        = 1'b1;
                    wr_data_d       = req_data[32'(pick_idx)*DW +: DW];
                    ack_d[pick_idx] = 1'b1;
                    grant_d         = pick_idx;
                    ptr_d           = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d         = WRITE;
                end
            end
            WRITE:      state_d = WAIT_FULL;
            WAIT_FULL:  if (reg_has_data)  state_d = WAIT_DRAIN;
            WAIT_DRAIN: if (!reg_has_data) state_d = WAIT_REL;
            // The register re-arms on the same edge the reader releases rd.
            WAIT_REL:   if (!reg_rd)       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ack_q     <= '0;
            reg_wr_q  <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            reg_wr_q  <= reg_wr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
        end
    end

    assign ack         = ack_q;
    assign reg_wr      = reg_wr_q;
    assign reg_wr_data = wr_data_q;
    assign busy        = busy_q;
    assign grant_idx   = grant_q;

endmodule
